sram_rw_port_ctrl: RTL



---
 rtl/sram_ctrl_pkg.sv | 16 +
 rtl/sram_ctrl_rsp_fifo.sv | 59 +++++
 rtl/sram_rw_port_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared constants and FSM encoding for the single-port SRAM controller.
package sram_ctrl_pkg;

    localparam int SRAM_ADDR_W    = 8;
    localparam int SRAM_WORDS     = 1 << SRAM_ADDR_W;
    localparam int SRAM_DATA_W    = 32;
    localparam int SRAM_LANE_W    = 8;
    localparam int SRAM_NUM_LANES = SRAM_DATA_W / SRAM_LANE_W;
    localparam int RD_LATENCY     = 2;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/sram_ctrl_rsp_fifo.sv
// Read-response FIFO; pointers wrap at RSP_DEPTH, so the depth need not be a power of two.
module sram_ctrl_rsp_fifo #(
    parameter int  DATA_WIDTH = 32,
    parameter int  RSP_DEPTH  = 4,
    localparam int PTR_W      = $clog2(RSP_DEPTH),
    localparam int CNT_W      = $clog2(RSP_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  pop_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0]      count_o
);

    logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Gate with occupancy so the output reads zero out of reset and holds while stalled.
    assign valid_o = (count_q != '0);
    assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/sram_rw_port_ctrl.sv
// Valid/ready front end for a 1RW SRAM port: optional zero-fill after reset,
// registered SRAM command outputs, and an in-order read-response buffer.
module sram_rw_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH    = SRAM_ADDR_W,
    parameter int DATA_WIDTH    = SRAM_DATA_W,
    parameter int NUM_WMASKS    = SRAM_NUM_LANES,
    parameter int RSP_DEPTH     = 4,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    ctrl_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
    logic                  init_done_q, init_done_d;
    logic                  csb_q, csb_d, web_q, web_d;
    logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [RD_LATENCY-1:0] rd_vld_q;
    logic [1:0]            inflight_q, inflight_d;
    logic [CNT_W-1:0]      rsp_count;
    logic                  req_fire, rd_fire, rsp_push;

    // Reserve a buffer slot for every read from accept until it is consumed.
    assign req_ready = !rst && (state_q == RUN) &&
                       (req_we || ((int'(rsp_count) + int'(inflight_q)) < RSP_DEPTH));
    assign req_fire  = req_valid && req_ready;
    assign rd_fire   = req_fire && !req_we;
    assign rsp_push  = rd_vld_q[RD_LATENCY-1];

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        init_done_d = init_done_q;
        csb_d       = 1'b1;
        web_d       = 1'b1;
        wmask_d     = '0;
        addr_d      = '0;
        din_d       = '0;
        unique case (state_q)
            INIT: begin
                csb_d       = 1'b0;
                web_d       = 1'b0;
                wmask_d     = '1;
                addr_d      = init_addr_q;
                init_addr_d = init_addr_q + 1'b1;
                if (init_addr_q == '1) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                init_done_d = 1'b1;
                if (req_fire) begin
                    csb_d   = 1'b0;
                    web_d   = ~req_we;
                    wmask_d = req_we ? req_wmask : '0;
                    addr_d  = req_addr;
                    din_d   = req_wdata;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        unique case ({rd_fire, rsp_push})
            2'b10:   inflight_d = inflight_q + 2'd1;
            2'b01:   inflight_d = inflight_q - 2'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT_ON_RESET ? INIT : RUN;
            init_addr_q <= '0;
            init_done_q <= 1'b0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            wmask_q     <= '0;
            addr_q      <= '0;
            din_q       <= '0;
            rd_vld_q    <= '0;
            inflight_q  <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            init_done_q <= init_done_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            wmask_q     <= wmask_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            rd_vld_q    <= {rd_vld_q[RD_LATENCY-2:0], rd_fire};
            inflight_q  <= inflight_d;
        end
    end

    sram_ctrl_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .RSP_DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rsp_push),
        .wdata_i (sram_dout0),
        .pop_i   (rsp_valid && rsp_ready),
        .valid_o (rsp_valid),
        .rdata_o (rsp_rdata),
        .count_o (rsp_count)
    );

    assign init_done   = init_done_q;
    assign sram_csb0   = csb_q;
    assign sram_web0   = web_q;
    assign sram_wmask0 = wmask_q;
    assign sram_addr0  = addr_q;
    assign sram_din0   = din_q;

endmodule
